bayer_window_ctrl: RTL and testbench

//  Sits upstream of the Bayer demosaic stage. Takes a raster AXI-stream Bayer pixel stream and

---
 rtl/bayer_window_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_bayer_window_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_window_ctrl.sv
// Bayer 3-row window scheduler: two line buffers feed rows r-1/r/r+1 to demosaic.
// Define BAYER_WIN_STATS_EN to enable the completed-frame counter on frame_cnt.
module bayer_window_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_bayer_type,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] matrix_data01,
  output logic [DATA_WIDTH-1:0] matrix_data11,
  output logic [DATA_WIDTH-1:0] matrix_data21,
  output logic [1:0]            bayer_type,
  output logic                  err_sticky,
  output logic [15:0]           frame_cnt
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [11:0] WLAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] HLAST = 12'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DROP
  } state_t;

  state_t state_q, state_d, eff;

  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic [11:0] cur_col, cur_row;
  logic [1:0]  bt_q, bt_d;
  logic        err_q, err_d;
  logic        ov_q, ov_d;
  logic        ou_q, ou_d;
  logic        ol_q, ol_d;
  logic [DATA_WIDTH-1:0] d01_q, d01_d;
  logic [DATA_WIDTH-1:0] d11_q, d11_d;
  logic [DATA_WIDTH-1:0] d21_q, d21_d;

  logic acc, sof, col_end, eol, line_err, wr_en;
  logic [AW-1:0] addr;
  logic [DATA_WIDTH-1:0] rd0, rd1;

  logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];

  assign s_axis_tready = (state_q != S_FLUSH);
  assign acc = s_axis_tvalid & s_axis_tready;
  assign sof = acc & s_axis_tuser;

  // A start-of-frame pixel is processed as row 0 col 0 of a fresh frame
  assign eff = sof ? (cfg_enable ? S_FILL : S_DROP) : state_q;
  assign cur_col = sof ? 12'd0 : col_q;
  assign cur_row = sof ? 12'd0 : row_q;

  assign col_end  = (cur_col == WLAST);
  assign eol      = s_axis_tlast | col_end;
  assign line_err = s_axis_tlast ^ col_end;

  assign addr = cur_col[AW-1:0];
  assign rd0  = lb0_q[addr];
  assign rd1  = lb1_q[addr];

  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      lb1_q[addr] <= rd0;
      lb0_q[addr] <= s_axis_tdata;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    bt_d    = bt_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    ou_d    = 1'b0;
    ol_d    = 1'b0;
    d01_d   = d01_q;
    d11_d   = d11_q;
    d21_d   = d21_q;
    wr_en   = 1'b0;

    if (sof) begin
      bt_d = cfg_bayer_type;
      if (state_q != S_IDLE) err_d = 1'b1;
    end

    unique case (eff)
      S_IDLE: begin
      end
      S_FILL, S_RUN, S_DROP: begin
        if (acc) begin
          state_d = eff;
          row_d   = cur_row;
          col_d   = cur_col + 12'd1;
          wr_en   = (eff != S_DROP);
          if (line_err) err_d = 1'b1;
          if (eff == S_RUN) begin
            ov_d  = 1'b1;
            ou_d  = (cur_row == 12'd1) && (cur_col == 12'd0);
            ol_d  = col_end;
            d01_d = (cur_row == 12'd1) ? '0 : rd1;
            d11_d = rd0;
            d21_d = s_axis_tdata;
          end
          if (eol) begin
            col_d = 12'd0;
            row_d = cur_row + 12'd1;
            if (eff == S_FILL) begin
              state_d = S_RUN;
            end else if (cur_row == HLAST) begin
              state_d = (eff == S_RUN) ? S_FLUSH : S_IDLE;
              row_d   = 12'd0;
            end
          end
        end
      end
      S_FLUSH: begin
        ov_d  = 1'b1;
        ol_d  = col_end;
        d01_d = rd1;
        d11_d = rd0;
        d21_d = '0;
        col_d = cur_col + 12'd1;
        if (col_end) begin
          col_d   = 12'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      bt_q    <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      ou_q    <= 1'b0;
      ol_q    <= 1'b0;
      d01_q   <= '0;
      d11_q   <= '0;
      d21_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      bt_q    <= bt_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      ou_q    <= ou_d;
      ol_q    <= ol_d;
      d01_q   <= d01_d;
      d11_q   <= d11_d;
      d21_q   <= d21_d;
    end
  end

  assign m_axis_tvalid = ov_q;
  assign m_axis_tuser  = ou_q;
  assign m_axis_tlast  = ol_q;
  assign matrix_data01 = d01_q;
  assign matrix_data11 = d11_q;
  assign matrix_data21 = d21_q;
  assign bayer_type    = bt_q;
  assign err_sticky    = err_q;

`ifdef BAYER_WIN_STATS_EN
  logic [15:0] fc_q;
  logic        flush_done;

  assign flush_done = (state_q == S_FLUSH) && (col_q == WLAST);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      fc_q <= '0;
    end else if (flush_done) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_cnt = fc_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_bayer_window_ctrl.sv
// Directed bench for bayer_window_ctrl at 8x4 pixels, 10-bit samples.
// Expected windows come from a pixel=row*16+col model of the 3-row window.
module tb_bayer_window_ctrl;
  localparam int DW = 10;
  localparam int W  = 8;
  localparam int H  = 4;
`ifdef BAYER_WIN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic [DW-1:0] s_axis_tdata;
  logic          cfg_enable;
  logic [1:0]    cfg_bayer_type;
  logic          m_axis_tvalid;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic [DW-1:0] matrix_data01;
  logic [DW-1:0] matrix_data11;
  logic [DW-1:0] matrix_data21;
  logic [1:0]    bayer_type;
  logic          err_sticky;
  logic [15:0]   frame_cnt;

  bayer_window_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .pixel_clk     (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .cfg_enable    (cfg_enable),
    .cfg_bayer_type(cfg_bayer_type),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .matrix_data01 (matrix_data01),
    .matrix_data11 (matrix_data11),
    .matrix_data21 (matrix_data21),
    .bayer_type    (bayer_type),
    .err_sticky    (err_sticky),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fc_exp = 0;
  int last_wait = 0;
  logic [31:0] win_q[$];

  typedef struct {
    int         idx;
    logic [9:0] e01;
    logic [9:0] e11;
    logic [9:0] e21;
    logic       eu;
    logic       el;
  } vec_t;

  vec_t tab [6];

  always @(negedge clk) begin
    if (m_axis_tvalid)
      win_q.push_back({matrix_data01, matrix_data11, matrix_data21,
                       m_axis_tuser, m_axis_tlast});
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] px(input int r, input int c);
    return 10'(r * 16 + c);
  endfunction

  function automatic logic [31:0] win(input int o, input int c);
    logic [9:0] a, b, d;
    logic u, l;
    a = (o == 0) ? 10'd0 : px(o - 1, c);
    b = px(o, c);
    d = (o == H - 1) ? 10'd0 : px(o + 1, c);
    u = (o == 0 && c == 0) ? 1'b1 : 1'b0;
    l = (c == W - 1) ? 1'b1 : 1'b0;
    return {a, b, d, u, l};
  endfunction

  function automatic logic [31:0] cur_win();
    return {matrix_data01, matrix_data11, matrix_data21,
            m_axis_tuser, m_axis_tlast};
  endfunction

  task automatic send_pix(input logic [9:0] d, input bit u, input bit l,
                          input int gap, input bit lat,
                          input logic [31:0] exp_w);
    int n;
    bit ok;
    for (int g = 0; g < gap; g++) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      if (lat) chk("gap_idle", {31'd0, m_axis_tvalid}, 32'd0);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    n = 0;
    forever begin
      ok = s_axis_tready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout waited=%0d required<=50", n);
        break;
      end
    end
    last_wait = n;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    if (lat) begin
      chk("lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("lat_data", cur_win(), exp_w);
    end
  endtask

  task automatic send_frame(input bit gaps, input bit lat, input bit tog);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pix(px(r, c), (r == 0 && c == 0), (c == W - 1),
                 gaps ? int'($urandom_range(0, 1)) : 0,
                 lat && (r >= 1), (r >= 1) ? win(r - 1, c) : 32'd0);
        if (tog && r == 0 && c == 0) cfg_bayer_type = 2'b11;
        if (tog && r == 2 && c == 0)
          chk("bt_hold_mid", {30'd0, bayer_type}, 32'd1);
      end
    end
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (!s_axis_tready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string name);
    chk({name, "_count"}, win_q.size(), 32);
    for (int o = 0; o < H; o++)
      for (int c = 0; c < W; c++)
        chk({name, "_seq"}, win_q[o * W + c], win(o, c));
  endtask

  initial begin
    int n;
    tab[0] = '{0,  10'h000, 10'h000, 10'h010, 1'b1, 1'b0};
    tab[1] = '{3,  10'h000, 10'h003, 10'h013, 1'b0, 1'b0};
    tab[2] = '{7,  10'h000, 10'h007, 10'h017, 1'b0, 1'b1};
    tab[3] = '{11, 10'h003, 10'h013, 10'h023, 1'b0, 1'b0};
    tab[4] = '{24, 10'h020, 10'h030, 10'h000, 1'b0, 1'b0};
    tab[5] = '{31, 10'h027, 10'h037, 10'h000, 1'b0, 1'b1};

    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    cfg_enable = 1'b1;
    cfg_bayer_type = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd1);
    chk("rst_mout", {29'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast}, 32'd0);
    chk("rst_data", cur_win(), 32'd0);
    chk("rst_status", {14'd0, bayer_type, err_sticky, frame_cnt}, 32'd0);

    // gapless frame, bayer 10
    win_q.delete();
    cfg_bayer_type = 2'b10;
    send_frame(1'b0, 1'b1, 1'b0);
    wait_flush(n);
    chk("flush_tready_low", n, 8);
    chk_frame("gapless");
    foreach (tab[i])
      chk("table", win_q[tab[i].idx],
          {tab[i].e01, tab[i].e11, tab[i].e21, tab[i].eu, tab[i].el});
    fc_exp += STATS;
    chk("fc_frame1", frame_cnt, fc_exp);
    chk("bt_frame1", {30'd0, bayer_type}, 32'd2);
    chk("err_clean", {31'd0, err_sticky}, 32'd0);

    // random gaps, bayer 01 with mid-frame cfg toggle
    win_q.delete();
    cfg_bayer_type = 2'b01;
    send_frame(1'b1, 1'b1, 1'b1);
    wait_flush(n);
    chk("gap_flush_low", n, 8);
    chk_frame("gaps");
    chk("bt_frame2", {30'd0, bayer_type}, 32'd1);
    fc_exp += STATS;
    chk("fc_frame2", frame_cnt, fc_exp);

    // disabled frame is consumed silently
    win_q.delete();
    cfg_enable = 1'b0;
    cfg_bayer_type = 2'b00;
    send_frame(1'b0, 1'b0, 1'b0);
    chk("drop_tready", {31'd0, s_axis_tready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("drop_windows", win_q.size(), 0);
    chk("drop_fc", frame_cnt, fc_exp);
    chk("drop_bt", {30'd0, bayer_type}, 32'd0);
    cfg_enable = 1'b1;

    // short line: tlast at col 5 of row 2
    win_q.delete();
    cfg_bayer_type = 2'b11;
    for (int r = 0; r < H; r++) begin
      int cnt;
      cnt = (r == 2) ? 6 : W;
      for (int c = 0; c < cnt; c++) begin
        logic [31:0] e;
        if (r == 2 && c == 0)
          chk("err_before", {31'd0, err_sticky}, 32'd0);
        if (r == 3 && c >= 6)
          e = {px(0, c), px(1, c), px(3, c), 1'b0, (c == W - 1)};
        else
          e = (r >= 1) ? win(r - 1, c) : 32'd0;
        send_pix(px(r, c), (r == 0 && c == 0), (c == cnt - 1), 0,
                 (r >= 1), e);
      end
    end
    chk("err_short_line", {31'd0, err_sticky}, 32'd1);
    wait_flush(n);
    chk("err_flush_low", n, 8);
    fc_exp += STATS;
    chk("fc_err_frame", frame_cnt, fc_exp);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fc_exp = 0;
    chk("rst2_status", {14'd0, bayer_type, err_sticky, frame_cnt}, 32'd0);

    // early tuser at row 2 col 4 aborts without flush
    cfg_bayer_type = 2'b00;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 4 : W); c++)
        send_pix(px(r, c), (r == 0 && c == 0), (c == W - 1), 0,
                 1'b0, 32'd0);
    @(negedge clk); #1;
    win_q.delete();
    send_pix(px(0, 0), 1'b1, 1'b0, 0, 1'b0, 32'd0);
    chk("abort_no_flush", last_wait, 0);
    chk("err_early_sof", {31'd0, err_sticky}, 32'd1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r != 0 || c != 0)
          send_pix(px(r, c), 1'b0, (c == W - 1), 0, (r >= 1),
                   (r >= 1) ? win(r - 1, c) : 32'd0);
    wait_flush(n);
    chk("abort_flush_low", n, 8);
    chk_frame("restart");
    fc_exp += STATS;
    chk("fc_restart", frame_cnt, fc_exp);

    // reset mid-frame, then headless pixels are ignored
    cfg_bayer_type = 2'b10;
    for (int i = 0; i < W + 3; i++)
      send_pix(px(i / W, i % W), (i == 0), ((i % W) == W - 1), 0,
               1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_mout", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_status",
        {13'd0, s_axis_tready, bayer_type, err_sticky, frame_cnt},
        32'h0008_0000);
    win_q.delete();
    for (int c = 0; c < W; c++)
      send_pix(px(1, c), 1'b0, (c == W - 1), 0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("headless_windows", win_q.size(), 0);
    chk("headless_err", {31'd0, err_sticky}, 32'd0);
    win_q.delete();
    send_frame(1'b0, 1'b1, 1'b0);
    wait_flush(n);
    chk("fresh_flush_low", n, 8);
    chk_frame("fresh");
    fc_exp = STATS;
    chk("fc_fresh", frame_cnt, fc_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
